sram_access_scheduler: RTL and testbench
========================================

Name: sram_access_scheduler

Overview:
- Shares the single external 8-bit SRAM between three requesters:
  - video fetch (CRTC/GA pixel reads)
  - CPU memory accesses
  - host ROM/boot loader writes
- Sits between the memory manager's requester logic and the SRAM pins.
- Runs a fixed-length access sequence (setup / strobe / complete) with priority arbitration and a host anti-starvation guard.

Parameters:
- AW, 21, SRAM address width.
- WAIT_STATES, 2, cycles in ACCESS state (legal range 1..15).
- HOST_MAX, 4, consecutive CPU grants allowed while host is waiting before host is forced ahead of CPU (legal range 1..15).

Ports:
- ck16  in  1  system clock (16 MHz).
- rst  in  1  asynchronous reset, active high.
- vid_req  in  1  video read request, level, held until vid_ack.
- vid_addr  in  AW  video address, stable while vid_req.
- vid_ack  out  1  one-cycle completion pulse.
- vid_rdata  out  8  video read data, valid when vid_ack, held until next video completion.
- cpu_req  in  1  CPU request, level, held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  8  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  8  CPU read data, valid when cpu_ack, held.
- host_req  in  1  host write request, level.
- host_addr  in  AW  host address.
- host_wdata  in  8  host write data.
- host_ack  out  1  one-cycle completion pulse.
- sram_addr  out  AW  SRAM address.
- sram_dout  out  8  data driven to SRAM.
- sram_doe  out  1  1 = drive sram_dout onto the bus.
- sram_din  in  8  data from SRAM.
- sram_we_n  out  1  SRAM write strobe, active low.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, immediate):
  - state IDLE, all acks 0, sram_we_n 1, sram_doe 0.
  - sram_addr 0, sram_dout 0, vid_rdata/cpu_rdata 0.
  - starvation counter 0, wait counter 0.
- States: IDLE -> SETUP -> ACCESS -> DONE -> IDLE.
- IDLE: sample requests at the clock edge. Priority order:
  - vid_req.
  - else host_req, if starve_cnt == HOST_MAX.
  - else cpu_req.
  - else host_req.
  - None asserted: stay in IDLE.
- Grant action: register the winner's id, address, write flag (video always read, host always write) and write data; go to SETUP.
- SETUP (1 cycle): sram_addr driven; for a write, sram_doe = 1 and sram_we_n = 1.
- ACCESS (WAIT_STATES cycles, counted by a 4-bit counter): for a write, sram_we_n = 0; for a read, sram_doe = 0.
- On the edge leaving the last ACCESS cycle:
  - read: capture sram_din into the winner's rdata register.
  - sram_we_n returns to 1.
- DONE (1 cycle): winner's ack = 1. Address and data held; sram_doe still 1 for a write (hold time). Then IDLE.
- sram_we_n is 0 only in ACCESS for writes. Address/data never change while sram_we_n = 0.
- Latency: request seen in IDLE at edge 0 -> ack high during cycle 3+WAIT_STATES-1, i.e. cycle 4 with default.
- Back-to-back access period = 3 + WAIT_STATES cycles (5 default). Requests arriving mid-access wait for IDLE.
- Starvation counter (4-bit, saturating at HOST_MAX):
  - increments on each CPU grant while host_req = 1.
  - clears on host grant, or in any IDLE cycle with host_req = 0.
  - unaffected by video grants.
- Requester drops req mid-access: access completes and ack still pulses. Requester must ignore the stale ack.
- A requester keeping req high in the DONE cycle is re-arbitrated normally in the next IDLE cycle. Ack is the only completion indication.
- Registered outputs only; no combinational path from req to sram pins.

Test Plan:
- Reset mid-write (assert rst during ACCESS with sram_we_n = 0) -> sram_we_n = 1, sram_doe = 0, busy = 0 within the same cycle; no ack after rst release.
- CPU read at 0x04000, SRAM model returns 0x5A, WAIT_STATES = 2:
  - cpu_ack exactly 4 cycles after the grant edge; cpu_rdata = 0x5A and held.
  - sram_we_n stays 1 throughout.
- vid_req, cpu_req and host_req asserted in the same cycle -> grants in order video, CPU, host:
  - acks 5 cycles apart.
  - video data correct; host write 0xA5 at 0x1FFFFF lands in the model.
- cpu_req held continuously plus host_req, HOST_MAX = 4 -> grant pattern C C C C H C C C C H.
- Video request arriving during a CPU ACCESS -> CPU completes first; video granted in the next IDLE cycle, ack 5 cycles after cpu_ack.
- CPU write 0x3C to 0x00010:
  - sram_we_n low for exactly WAIT_STATES cycles.
  - sram_addr and sram_dout stable from SETUP through DONE.
  - sram_doe high from SETUP through DONE.

Source files
------------

// File: rtl/sram_access_scheduler.sv
// sram_access_scheduler
//   Time-shares one external 8-bit SRAM between video fetch (read only),
//   CPU (read/write) and host loader (write only). Every access runs
//   IDLE -> SETUP -> ACCESS (WAIT_STATES cycles) -> DONE -> IDLE.
//   Priority: video, then host if it has been passed over HOST_MAX times by
//   the CPU, then CPU, then host.
// Ports:
//   ck16, rst                      clock, async active-high reset
//   vid_req/addr/ack/rdata         video read channel
//   cpu_req/we/addr/wdata/ack/rdata CPU channel
//   host_req/addr/wdata/ack        host write channel
//   sram_addr/dout/doe/din/we_n    SRAM pins (all outputs registered)
//   busy                           scheduler not in IDLE
module sram_access_scheduler #(
  parameter int AW          = 21,
  parameter int WAIT_STATES = 2,
  parameter int HOST_MAX    = 4
) (
  input  logic          ck16,
  input  logic          rst,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_ack,
  output logic [7:0]    vid_rdata,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_wdata,
  output logic          cpu_ack,
  output logic [7:0]    cpu_rdata,
  input  logic          host_req,
  input  logic [AW-1:0] host_addr,
  input  logic [7:0]    host_wdata,
  output logic          host_ack,
  output logic [AW-1:0] sram_addr,
  output logic [7:0]    sram_dout,
  output logic          sram_doe,
  input  logic [7:0]    sram_din,
  output logic          sram_we_n,
  output logic          busy
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;
  typedef enum logic [1:0] {OWN_VID, OWN_CPU, OWN_HOST} owner_t;

  localparam logic [3:0] WS_LAST = 4'(WAIT_STATES - 1);
  localparam logic [3:0] HMAX    = 4'(HOST_MAX);

  state_t     state, state_nx;
  owner_t     owner, grant_owner;
  logic       grant;
  logic       last_access;
  logic       wr;
  logic [3:0] wait_cnt;
  logic [3:0] starve_cnt;

  always_comb begin
    state_nx    = state;
    grant       = 1'b0;
    grant_owner = OWN_VID;
    last_access = (wait_cnt == WS_LAST);
    unique case (state)
      S_IDLE: begin
        if (vid_req) begin
          grant       = 1'b1;
          grant_owner = OWN_VID;
        end else if (host_req && starve_cnt == HMAX) begin
          grant       = 1'b1;
          grant_owner = OWN_HOST;
        end else if (cpu_req) begin
          grant       = 1'b1;
          grant_owner = OWN_CPU;
        end else if (host_req) begin
          grant       = 1'b1;
          grant_owner = OWN_HOST;
        end
        if (grant) state_nx = S_SETUP;
      end
      S_SETUP:  state_nx = S_ACCESS;
      S_ACCESS: if (last_access) state_nx = S_DONE;
      S_DONE:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge ck16 or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge ck16 or posedge rst) begin
    if (rst) begin
      owner      <= OWN_VID;
      wr         <= 1'b0;
      wait_cnt   <= '0;
      starve_cnt <= '0;
      sram_addr  <= '0;
      sram_dout  <= '0;
      sram_doe   <= 1'b0;
      sram_we_n  <= 1'b1;
      vid_ack    <= 1'b0;
      cpu_ack    <= 1'b0;
      host_ack   <= 1'b0;
      vid_rdata  <= '0;
      cpu_rdata  <= '0;
    end else begin
      vid_ack  <= 1'b0;
      cpu_ack  <= 1'b0;
      host_ack <= 1'b0;
      unique case (state)
        S_IDLE: begin
          // Video grants leave the counter alone unless host has gone quiet.
          if (!host_req || (grant && grant_owner == OWN_HOST))
            starve_cnt <= '0;
          else if (grant && grant_owner == OWN_CPU && starve_cnt != HMAX)
            starve_cnt <= starve_cnt + 4'd1;
          if (grant) begin
            owner <= grant_owner;
            case (grant_owner)
              OWN_CPU: begin
                sram_addr <= cpu_addr;
                wr        <= cpu_we;
                sram_doe  <= cpu_we;
                if (cpu_we) sram_dout <= cpu_wdata;
              end
              OWN_HOST: begin
                sram_addr <= host_addr;
                wr        <= 1'b1;
                sram_doe  <= 1'b1;
                sram_dout <= host_wdata;
              end
              default: begin
                sram_addr <= vid_addr;
                wr        <= 1'b0;
                sram_doe  <= 1'b0;
              end
            endcase
          end
        end
        S_SETUP: begin
          wait_cnt <= '0;
          if (wr) sram_we_n <= 1'b0;
        end
        S_ACCESS: begin
          if (last_access) begin
            sram_we_n <= 1'b1;
            case (owner)
              OWN_CPU: begin
                cpu_ack <= 1'b1;
                if (!wr) cpu_rdata <= sram_din;
              end
              OWN_HOST: host_ack <= 1'b1;
              default: begin
                vid_ack   <= 1'b1;
                vid_rdata <= sram_din;
              end
            endcase
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        S_DONE: sram_doe <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_access_scheduler.sv
// Self-checking bench for sram_access_scheduler: directed scenarios followed
// by random traffic, all checked every cycle against a transaction-level model.
module tb_sram_access_scheduler;
  localparam int AW = 21;
  localparam int WS = 2;
  localparam int HM = 4;

  logic          ck16 = 1'b0;
  logic          rst  = 1'b1;
  logic          vid_req = 1'b0, cpu_req = 1'b0, host_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] vid_addr = '0, cpu_addr = '0, host_addr = '0;
  logic [7:0]    cpu_wdata = '0, host_wdata = '0, sram_din = '0;
  logic          vid_ack, cpu_ack, host_ack, sram_doe, sram_we_n, busy;
  logic [7:0]    vid_rdata, cpu_rdata, sram_dout;
  logic [AW-1:0] sram_addr;

  always #5 ck16 = ~ck16;

  sram_access_scheduler #(.AW(AW), .WAIT_STATES(WS), .HOST_MAX(HM)) dut (
    .ck16(ck16), .rst(rst),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_addr(host_addr), .host_wdata(host_wdata), .host_ack(host_ack),
    .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_doe(sram_doe),
    .sram_din(sram_din), .sram_we_n(sram_we_n), .busy(busy)
  );

  logic [7:0] sram_mem [int];
  logic [7:0] ref_mem  [int];
  int n_chk = 0, n_pass = 0, n_fail = 0, cyc_no = 0;
  int we_low_cnt = 0, doe_hi_cnt = 0;

  // Model: one access occupies WS+3 cycles from the grant edge back to IDLE.
  int idle_cnt = 0, ack_cnt = -1, starve = 0, cur_who = 0;
  logic          cur_wr = 1'b0;
  logic [AW-1:0] cur_addr = '0;
  logic [7:0]    cur_wdata = '0, pend_rd = '0, exp_vrd = '0, exp_crd = '0;
  int ack_who[$];
  int ack_cyc[$];
  bit cpu_auto = 0, host_auto = 0;

  function automatic logic [7:0] init_val(int a);
    return 8'(a ^ (a >> 8) ^ 8'h33);
  endfunction
  function automatic logic [7:0] sram_rd(int a);
    return sram_mem.exists(a) ? sram_mem[a] : init_val(a);
  endfunction
  function automatic logic [7:0] ref_rd(int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic post_vid(input logic [AW-1:0] a);
    vid_req = 1'b1; vid_addr = a;
  endtask
  task automatic post_cpu(input logic we, input logic [AW-1:0] a, input logic [7:0] d);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask
  task automatic post_host(input logic [AW-1:0] a, input logic [7:0] d);
    host_req = 1'b1; host_addr = a; host_wdata = d;
  endtask

  // SRAM pin model: writes while we_n is low, read data presented for the next edge.
  task automatic tick();
    @(negedge ck16);
    cyc_no++;
    if (!sram_we_n) begin
      sram_mem[int'(sram_addr)] = sram_dout;
      we_low_cnt++;
    end
    if (sram_doe) doe_hi_cnt++;
    sram_din = sram_rd(int'(sram_addr));
  endtask

  task automatic check_outs();
    chk("vid_ack",  {31'b0, vid_ack},  {31'b0, ack_cnt == 0 && cur_who == 0});
    chk("cpu_ack",  {31'b0, cpu_ack},  {31'b0, ack_cnt == 0 && cur_who == 1});
    chk("host_ack", {31'b0, host_ack}, {31'b0, ack_cnt == 0 && cur_who == 2});
    chk("busy",     {31'b0, busy},     {31'b0, idle_cnt > 0});
    chk("we_n",     {31'b0, sram_we_n}, {31'b0, !(cur_wr && idle_cnt >= 2 && idle_cnt <= WS + 1)});
    chk("doe",      {31'b0, sram_doe}, {31'b0, cur_wr && idle_cnt >= 1});
    chk("addr",     32'(sram_addr), 32'(cur_addr));
    if (cur_wr && idle_cnt >= 1) chk("dout", 32'(sram_dout), 32'(cur_wdata));
    chk("vid_rdata", 32'(vid_rdata), 32'(exp_vrd));
    chk("cpu_rdata", 32'(cpu_rdata), 32'(exp_crd));
  endtask

  task automatic step_pre();
    tick();
    if (idle_cnt > 0) idle_cnt--;
    if (ack_cnt >= 0) ack_cnt--;
    if (ack_cnt == 0) begin
      if (cur_wr) ref_mem[int'(cur_addr)] = cur_wdata;
      else if (cur_who == 0) exp_vrd = pend_rd;
      else exp_crd = pend_rd;
    end
    check_outs();
    if (vid_ack)  begin ack_who.push_back(0); ack_cyc.push_back(cyc_no); end
    if (cpu_ack)  begin ack_who.push_back(1); ack_cyc.push_back(cyc_no); end
    if (host_ack) begin ack_who.push_back(2); ack_cyc.push_back(cyc_no); end
    if (ack_cnt == 0) begin
      case (cur_who)
        0: vid_req = 1'b0;
        1: begin
          cpu_req = 1'b0;
          if (cpu_auto) post_cpu($urandom_range(0, 1) == 1, AW'($urandom_range(0, 63)), 8'($urandom));
        end
        default: begin
          host_req = 1'b0;
          if (host_auto) post_host(AW'($urandom_range(0, 63)), 8'($urandom));
        end
      endcase
    end
  endtask

  // Arbitration rules applied to the request levels the DUT sees at the next edge.
  task automatic step_post();
    int w;
    w = -1;
    if (idle_cnt == 0 && !rst) begin
      if (!host_req) starve = 0;
      if (vid_req) w = 0;
      else if (host_req && starve == HM) w = 2;
      else if (cpu_req) w = 1;
      else if (host_req) w = 2;
      if (w >= 0) begin
        if (w == 2) starve = 0;
        else if (w == 1 && host_req && starve < HM) starve++;
        cur_who  = w;
        idle_cnt = WS + 3;
        ack_cnt  = WS + 2;
        case (w)
          0: begin cur_wr = 1'b0; cur_addr = vid_addr; end
          1: begin cur_wr = cpu_we; cur_addr = cpu_addr; cur_wdata = cpu_we ? cpu_wdata : cur_wdata; end
          default: begin cur_wr = 1'b1; cur_addr = host_addr; cur_wdata = host_wdata; end
        endcase
        if (!cur_wr) pend_rd = ref_rd(int'(cur_addr));
      end
    end
  endtask

  task automatic cyc();
    step_post();
    step_pre();
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (k < 300 && (idle_cnt > 0 || vid_req || cpu_req || host_req)) begin
      cyc();
      k++;
    end
    chk("drain_bound", {31'b0, k < 300}, 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int pat[10];
    pat = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};

    // Reset values
    tick();
    check_outs();
    chk("rst_we_n", {31'b0, sram_we_n}, 32'd1);
    rst = 1'b0;
    cyc();

    // CPU read of 0x04000 returning 0x5A
    sram_mem[32'h04000] = 8'h5A;
    ref_mem[32'h04000]  = 8'h5A;
    ack_who.delete(); ack_cyc.delete(); we_low_cnt = 0;
    post_cpu(1'b0, 21'h04000, 8'h00);
    g = cyc_no;
    drain();
    cyc(); cyc();
    chk("rd_ack_count", ack_who.size(), 32'd1);
    if (ack_who.size() == 1) chk("rd_ack_latency", ack_cyc[0] - g, 32'd4);
    chk("rd_data_held", 32'(cpu_rdata), 32'h5A);
    chk("rd_we_n_idle", we_low_cnt, 32'd0);

    // Simultaneous requests: video, CPU, host in that order, 5 cycles apart
    ack_who.delete(); ack_cyc.delete();
    post_vid(21'h00123);
    post_cpu(1'b0, 21'h00200, 8'h00);
    post_host(21'h1FFFFF, 8'hA5);
    drain();
    chk("tri_ack_count", ack_who.size(), 32'd3);
    if (ack_who.size() == 3) begin
      chk("tri_order0", ack_who[0], 32'd0);
      chk("tri_order1", ack_who[1], 32'd1);
      chk("tri_order2", ack_who[2], 32'd2);
      chk("tri_gap01", ack_cyc[1] - ack_cyc[0], 32'd5);
      chk("tri_gap12", ack_cyc[2] - ack_cyc[1], 32'd5);
    end
    chk("tri_vid_data", 32'(vid_rdata), 32'(init_val(32'h123)));
    chk("tri_host_mem", 32'(sram_rd(32'h1FFFFF)), 32'hA5);

    // CPU held continuously with host waiting: C C C C H C C C C H
    ack_who.delete(); ack_cyc.delete();
    cpu_auto = 1; host_auto = 1;
    post_cpu(1'b0, 21'h00010, 8'h00);
    post_host(21'h00020, 8'h11);
    for (int k = 0; k < 200 && ack_who.size() < 10; k++) cyc();
    cpu_auto = 0; host_auto = 0;
    drain();
    chk("starve_ack_count", {31'b0, ack_who.size() >= 10}, 32'd1);
    for (int i = 0; i < 10; i++)
      if (i < ack_who.size()) chk($sformatf("starve_grant%0d", i), ack_who[i], pat[i]);

    // Video arriving during a CPU access waits for the next IDLE
    ack_who.delete(); ack_cyc.delete();
    post_cpu(1'b0, 21'h00300, 8'h00);
    cyc(); cyc();
    post_vid(21'h00400);
    drain();
    chk("mid_ack_count", ack_who.size(), 32'd2);
    if (ack_who.size() == 2) begin
      chk("mid_first_cpu", ack_who[0], 32'd1);
      chk("mid_then_vid", ack_who[1], 32'd0);
      chk("mid_gap", ack_cyc[1] - ack_cyc[0], 32'd5);
    end

    // CPU write 0x3C to 0x00010
    we_low_cnt = 0; doe_hi_cnt = 0;
    post_cpu(1'b1, 21'h00010, 8'h3C);
    drain();
    chk("wr_we_low_cycles", we_low_cnt, WS);
    chk("wr_doe_cycles", doe_hi_cnt, WS + 2);
    chk("wr_mem", 32'(sram_rd(32'h10)), 32'h3C);

    // Reset while the write strobe is low
    post_host(21'h00777, 8'h99);
    for (int k = 0; k < 10 && sram_we_n; k++) cyc();
    chk("mid_rst_we_low", {31'b0, sram_we_n}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_we_n", {31'b0, sram_we_n}, 32'd1);
    chk("mid_rst_doe",  {31'b0, sram_doe},  32'd0);
    chk("mid_rst_busy", {31'b0, busy},      32'd0);
    host_req = 1'b0; vid_req = 1'b0; cpu_req = 1'b0;
    idle_cnt = 0; ack_cnt = -1; starve = 0; cur_who = 0; cur_wr = 1'b0;
    cur_addr = '0; exp_vrd = '0; exp_crd = '0;
    tick();
    ref_mem[32'h777] = sram_rd(32'h777);
    check_outs();
    rst = 1'b0;
    ack_who.delete(); ack_cyc.delete();
    for (int k = 0; k < 6; k++) cyc();
    chk("mid_rst_no_ack", ack_who.size(), 32'd0);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      if (!vid_req && $urandom_range(0, 3) == 0) post_vid(AW'($urandom_range(0, 63)));
      if (!cpu_req && $urandom_range(0, 3) == 0)
        post_cpu($urandom_range(0, 1) == 1, AW'($urandom_range(0, 63)), 8'($urandom));
      if (!host_req && $urandom_range(0, 5) == 0) post_host(AW'($urandom_range(0, 63)), 8'($urandom));
      cyc();
    end
    drain();
    foreach (ref_mem[a]) chk($sformatf("mem_%0h", a), 32'(sram_rd(a)), 32'(ref_mem[a]));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
